// File: rtl/clock_freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous signal over GATE_CYCLES clocks.
// Optional low/high alarm comparators are built when THRESH_CHECK_EN is defined.
module clock_freq_meter #(
   parameter int unsigned GATE_CYCLES = 100000000,
   parameter int unsigned CNT_W       = 27,
   parameter int unsigned MIN_EDGES   = 25000000,
   parameter int unsigned MAX_EDGES   = 25350000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sig_i,
   input  logic             start_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o,
   output logic             overflow_o,
   output logic             too_low_o,
   output logic             too_high_o
);

   localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, GATE, DONE} state_e;

   state_e           state_q, state_d;
   logic             s1_q, s2_q, s3_q;
   logic             edge_w;
   logic [GW-1:0]    gate_q, gate_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic             sat_q, sat_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             result_load;
   logic             at_max, inc_sat;
   logic [CNT_W-1:0] cnt_inc;

   assign edge_w  = s2_q & ~s3_q;
   assign at_max  = (edge_cnt_q == CNT_MAX);
   assign inc_sat = edge_w & at_max;
   // Hold at all-ones instead of wrapping; the sticky flag records that it happened.
   assign cnt_inc = at_max ? edge_cnt_q : edge_cnt_q + CNT_W'(edge_w);

   always_comb begin
      state_d     = state_q;
      gate_d      = gate_q;
      edge_cnt_d  = edge_cnt_q;
      sat_d       = sat_q;
      busy_d      = busy_q;
      valid_d     = valid_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      result_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = GATE;
               gate_d     = GATE_LAST;
               edge_cnt_d = '0;
               sat_d      = 1'b0;
               busy_d     = 1'b1;
            end
         end
         GATE: begin
            edge_cnt_d = cnt_inc;
            sat_d      = sat_q | inc_sat;
            gate_d     = gate_q - GW'(1);
            if (gate_q == '0) begin
               count_d     = cnt_inc;
               overflow_d  = sat_q | inc_sat;
               valid_d     = 1'b1;
               busy_d      = 1'b0;
               state_d     = DONE;
               result_load = 1'b1;
            end
         end
         DONE: begin
            if (ack_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         gate_q     <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= sig_i;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         gate_q     <= gate_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy_o     = busy_q;
   assign valid_o    = valid_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

`ifdef THRESH_CHECK_EN
   logic too_low_q, too_high_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         too_low_q  <= 1'b0;
         too_high_q <= 1'b0;
      end else if (result_load) begin
         too_low_q  <= 64'(count_d) < 64'(MIN_EDGES);
         too_high_q <= 64'(count_d) > 64'(MAX_EDGES);
      end
   end

   assign too_low_o  = too_low_q;
   assign too_high_o = too_high_q;
`else
   assign too_low_o  = 1'b0;
   assign too_high_o = 1'b0;
`endif

endmodule
